fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/pc_reg.sv | 34 +++
 rtl/fetch_stage.sv | 123 ++++++++++++
 tb/tb_fetch_stage.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared widths, encodings and fetch FSM state type for the core front end.
package cpu_pkg;
    localparam int OP_WIDTH    = 4;
    localparam int FUNCT_WIDTH = 4;
    localparam int INSTR_WIDTH = 16;
    localparam int PC_WIDTH    = 16;

    localparam logic [OP_WIDTH-1:0]    OP_HALT  = 4'hF;
    localparam logic [INSTR_WIDTH-1:0] BUBBLE   = 16'h0000;
    localparam logic [PC_WIDTH-1:0]    PC_RESET = 16'h0000;

    typedef enum logic [1:0] {
        ST_FETCH    = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_HALTED   = 2'd2
    } fetch_state_e;

    function automatic logic [PC_WIDTH-1:0] pc_inc(input logic [PC_WIDTH-1:0] pc);
        return pc + PC_WIDTH'(2);
    endfunction
endpackage

// File: rtl/pc_reg.sv
// Program counter with redirect/advance/hold next-PC selection.
module pc_reg
    import cpu_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pc_load,
    input  logic [PC_WIDTH-1:1] load_addr,
    input  logic                pc_adv,
    output logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] pc_plus2
);
    logic [PC_WIDTH-1:0] pc_d, pc_q;

    always_comb begin
        pc_d = pc_q;
        if (pc_load) begin
            pc_d = {load_addr, 1'b0};
        end else if (pc_adv) begin
            pc_d = pc_inc(pc_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= PC_RESET;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc       = pc_q;
    assign pc_plus2 = pc_inc(pc_q);
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, IF/ID pipeline register and fetch sequencing FSM.
//   state       | meaning
//   ST_FETCH    | last cycle accepted an instruction or was redirected
//   ST_WAIT_MEM | memory wait state, PC held, bubbles issued
//   ST_HALTED   | halt instruction reached decode; frozen until reset
module fetch_stage
    import cpu_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   imem_valid,
    input  logic                   stall,
    input  logic                   if_flush,
    input  logic                   pc_src,
    input  logic [PC_WIDTH-1:0]    branch_target,
    output logic [INSTR_WIDTH-1:0] ifid_instr,
    output logic [PC_WIDTH-1:0]    ifid_pc_plus2,
    output logic                   ifid_valid,
    output logic [OP_WIDTH-1:0]    opcode,
    output logic [FUNCT_WIDTH-1:0] funct_code,
    output logic                   halted,
    output logic [15:0]            fetch_count
);
    fetch_state_e           state_d, state_q;
    logic [INSTR_WIDTH-1:0] instr_d, instr_q;
    logic [PC_WIDTH-1:0]    pp2_d, pp2_q;
    logic                   valid_d, valid_q;
    logic                   halted_d, halted_q;
    logic [15:0]            count_d, count_q;
    logic                   pc_load, pc_adv;
    logic [PC_WIDTH-1:0]    pc, pc_plus2;
    logic                   halt_hit;

    pc_reg u_pc_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .pc_load   (pc_load),
        .load_addr (branch_target[PC_WIDTH-1:1]),
        .pc_adv    (pc_adv),
        .pc        (pc),
        .pc_plus2  (pc_plus2)
    );

    assign halt_hit = valid_q && (instr_q[INSTR_WIDTH-1 -: OP_WIDTH] == OP_HALT);

    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        pp2_d    = pp2_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        count_d  = count_q;
        pc_load  = 1'b0;
        pc_adv   = 1'b0;
        case (state_q)
            ST_FETCH, ST_WAIT_MEM: begin
                if (halt_hit) begin
                    state_d  = ST_HALTED;
                    halted_d = 1'b1;
                    instr_d  = BUBBLE;
                    valid_d  = 1'b0;
                end else if (pc_src) begin
                    pc_load = 1'b1;
                    state_d = ST_FETCH;
                    instr_d = BUBBLE;
                    valid_d = 1'b0;
                end else if (if_flush) begin
                    // a word arriving under flush is consumed and dropped
                    pc_adv  = imem_valid;
                    state_d = imem_valid ? ST_FETCH : ST_WAIT_MEM;
                    instr_d = BUBBLE;
                    valid_d = 1'b0;
                end else if (stall) begin
                    state_d = state_q;
                end else if (imem_valid) begin
                    pc_adv  = 1'b1;
                    state_d = ST_FETCH;
                    instr_d = imem_rdata;
                    pp2_d   = pc_plus2;
                    valid_d = 1'b1;
                    count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
                end else begin
                    state_d = ST_WAIT_MEM;
                    instr_d = BUBBLE;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d  = ST_HALTED;
                halted_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_FETCH;
            instr_q  <= BUBBLE;
            pp2_q    <= PC_RESET;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            count_q  <= 16'h0000;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            pp2_q    <= pp2_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            count_q  <= count_d;
        end
    end

    assign imem_addr     = pc;
    assign ifid_instr    = instr_q;
    assign ifid_pc_plus2 = pp2_q;
    assign ifid_valid    = valid_q;
    assign opcode        = instr_q[INSTR_WIDTH-1 -: OP_WIDTH];
    assign funct_code    = instr_q[FUNCT_WIDTH-1:0];
    assign halted        = halted_q;
    assign fetch_count   = count_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: rule-level model compared every cycle plus literal checks.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata = 16'h0;
    logic        imem_valid = 1'b0;
    logic        stall = 1'b0;
    logic        if_flush = 1'b0;
    logic        pc_src = 1'b0;
    logic [15:0] branch_target = 16'h0;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc_plus2;
    logic        ifid_valid;
    logic [3:0]  opcode;
    logic [3:0]  funct_code;
    logic        halted;
    logic [15:0] fetch_count;

    int checks = 0;
    int errors = 0;

    fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_valid    (imem_valid),
        .stall         (stall),
        .if_flush      (if_flush),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .ifid_instr    (ifid_instr),
        .ifid_pc_plus2 (ifid_pc_plus2),
        .ifid_valid    (ifid_valid),
        .opcode        (opcode),
        .funct_code    (funct_code),
        .halted        (halted),
        .fetch_count   (fetch_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the spec's per-cycle priority rules applied to plain variables.
    logic [15:0] m_pc = 16'h0, m_instr = 16'h0, m_pp2 = 16'h0, m_cnt = 16'h0;
    logic        m_valid = 1'b0, m_halted = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = 16'h0; m_instr = 16'h0; m_pp2 = 16'h0; m_cnt = 16'h0;
            m_valid = 1'b0; m_halted = 1'b0;
        end else if (!m_halted) begin
            if (m_valid && (m_instr >> 12) == 16'hF) begin
                m_halted = 1'b1; m_instr = 16'h0; m_valid = 1'b0;
            end else if (pc_src) begin
                m_pc = branch_target & 16'hFFFE; m_instr = 16'h0; m_valid = 1'b0;
            end else if (if_flush) begin
                m_instr = 16'h0; m_valid = 1'b0;
                if (imem_valid) m_pc = 16'((32'(m_pc) + 2) % 65536);
            end else if (stall) begin
                m_pc = m_pc;
            end else if (imem_valid) begin
                m_pc    = 16'((32'(m_pc) + 2) % 65536);
                m_instr = imem_rdata;
                m_pp2   = m_pc;
                m_valid = 1'b1;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end else begin
                m_instr = 16'h0; m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_imem_addr", imem_addr, m_pc);
        chk("cyc_ifid_instr", ifid_instr, m_instr);
        chk("cyc_ifid_pc_plus2", ifid_pc_plus2, m_pp2);
        chk("cyc_ifid_valid", 16'(ifid_valid), 16'(m_valid));
        chk("cyc_opcode", 16'(opcode), m_instr >> 12);
        chk("cyc_funct", 16'(funct_code), m_instr & 16'h000F);
        chk("cyc_halted", 16'(halted), 16'(m_halted));
        chk("cyc_fetch_count", fetch_count, m_cnt);
    end

    task automatic step(input logic v, input logic [15:0] rd, input logic st,
                        input logic fl, input logic ps, input logic [15:0] tg);
        imem_valid = v; imem_rdata = rd; stall = st; if_flush = fl;
        pc_src = ps; branch_target = tg;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_pc", imem_addr, 16'h0000);
        chk("rst_async_halted", 16'(halted), 16'h0);
        chk("rst_async_valid", 16'(ifid_valid), 16'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] lp;
        logic [15:0] rd;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_pc", imem_addr, 16'h0000);
        chk("reset_instr", ifid_instr, 16'h0000);
        chk("reset_valid", 16'(ifid_valid), 16'h0);
        chk("reset_count", fetch_count, 16'h0000);
        rst_n = 1'b1;

        step(1, 16'h1001, 0, 0, 0, 16'h0);
        chk("f1_instr", ifid_instr, 16'h1001);
        chk("f1_pp2", ifid_pc_plus2, 16'h0002);
        chk("f1_opcode", 16'(opcode), 16'h1);
        step(1, 16'h2002, 0, 0, 0, 16'h0);
        chk("f2_instr", ifid_instr, 16'h2002);
        chk("f2_pp2", ifid_pc_plus2, 16'h0004);
        chk("f2_count", fetch_count, 16'h0002);

        step(1, 16'h3333, 1, 0, 1, 16'h0041);
        chk("br_pc", imem_addr, 16'h0040);
        chk("br_valid", 16'(ifid_valid), 16'h0);
        chk("br_pp2_held", ifid_pc_plus2, 16'h0004);

        step(0, 16'h0, 0, 0, 1, 16'h0010);
        repeat (3) begin
            step(0, 16'h7777, 0, 0, 0, 16'h0);
            chk("wait_pc", imem_addr, 16'h0010);
            chk("wait_bubble", 16'(ifid_valid), 16'h0);
        end
        step(1, 16'h4567, 0, 0, 0, 16'h0);
        chk("resume_instr", ifid_instr, 16'h4567);
        chk("resume_pp2", ifid_pc_plus2, 16'h0012);
        chk("resume_funct", 16'(funct_code), 16'h7);

        repeat (2) begin
            step(1, 16'h9999, 1, 0, 0, 16'h0);
            chk("stall_instr", ifid_instr, 16'h4567);
            chk("stall_pc", imem_addr, 16'h0012);
            chk("stall_count", fetch_count, 16'h0003);
        end
        step(1, 16'h5A5A, 0, 0, 0, 16'h0);
        chk("unstall_instr", ifid_instr, 16'h5A5A);
        chk("unstall_count", fetch_count, 16'h0004);

        step(1, 16'h6666, 0, 1, 0, 16'h0);
        chk("flush_v_pc", imem_addr, 16'h0016);
        chk("flush_v_valid", 16'(ifid_valid), 16'h0);
        step(0, 16'h6666, 0, 1, 0, 16'h0);
        chk("flush_nv_pc", imem_addr, 16'h0016);
        step(1, 16'h6666, 1, 1, 1, 16'h0020);
        chk("br_over_flush_pc", imem_addr, 16'h0020);

        step(1, 16'hF000, 0, 0, 0, 16'h0);
        chk("halt_fetch_instr", ifid_instr, 16'hF000);
        step(1, 16'h1111, 0, 0, 1, 16'h0080);
        chk("halt_flag", 16'(halted), 16'h1);
        chk("halt_pc", imem_addr, 16'h0022);
        chk("halt_bubble", 16'(ifid_valid), 16'h0);
        step(1, 16'h2222, 0, 1, 1, 16'h0100);
        chk("halt_sticky", 16'(halted), 16'h1);
        chk("halt_pc2", imem_addr, 16'h0022);
        chk("halt_count", fetch_count, 16'h0005);

        reset_pulse();
        chk("post_halt_rst", 16'(halted), 16'h0);
        step(1, 16'hABCD, 0, 0, 0, 16'h0);
        chk("rst_fetch_instr", ifid_instr, 16'hABCD);
        chk("rst_fetch_pp2", ifid_pc_plus2, 16'h0002);

        step(0, 16'h0, 0, 0, 0, 16'h0);
        step(0, 16'h0, 0, 0, 0, 16'h0);
        reset_pulse();
        step(1, 16'h1234, 0, 0, 0, 16'h0);
        chk("wm_rst_pp2", ifid_pc_plus2, 16'h0002);
        chk("wm_rst_pc", imem_addr, 16'h0002);

        lp = 16'h0002;
        for (int i = 0; i < 65536; i++) begin
            rd = 16'($urandom_range(0, 16'hEFFF));
            step(1, rd, 0, 0, 0, 16'h0);
            if (lp == 16'hFFFE) begin
                chk("wrap_pc", imem_addr, 16'h0000);
                chk("wrap_pp2", ifid_pc_plus2, 16'h0000);
            end
            lp = lp + 16'd2;
        end
        chk("sat_count", fetch_count, 16'hFFFF);
        step(1, 16'h0123, 0, 0, 0, 16'h0);
        chk("sat_hold", fetch_count, 16'hFFFF);

        @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
